// File: rtl/lzc_norm_pipe.sv
// rtl/lzc_norm_pipe.sv - two-stage leading-zero count and left-shift normaliser with valid/ready flow.
// Optional LZC_ZERO_CNT_EN: enables the saturating zero_events counter; otherwise zero_events is tied low.
module lzc_norm_pipe #(
  parameter int W     = 24,
  parameter int TAG_W = 4,
  localparam int CW   = (W > 1) ? $clog2(W) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_zero,
  output logic [W-1:0]     out_norm,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      zero_events
);

  logic             s1_valid_q;
  logic [W-1:0]     s1_data_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [CW-1:0]    s1_count_q;
  logic             s1_zero_q;

  logic             s2_valid_q;
  logic [W-1:0]     s2_norm_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic [CW-1:0]    s2_count_q;
  logic             s2_zero_q;

  logic [CW-1:0]    lz_d;
  logic             zero_d;
  logic             found;
  logic             s1_load;
  logic             s2_load;

  // Scan from the MSB; the first set bit fixes the count. All-zero leaves count at 0.
  always_comb begin
    lz_d  = '0;
    found = 1'b0;
    for (int i = W-1; i >= 0; i--) begin
      if (!found && in_data[i]) begin
        found = 1'b1;
        lz_d  = CW'(W-1-i);
      end
    end
    zero_d = ~found;
  end

  assign s2_load  = ~s2_valid_q | out_ready;
  assign s1_load  = ~s1_valid_q | s2_load;
  assign in_ready = s1_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_tag_q   <= '0;
      s1_count_q <= '0;
      s1_zero_q  <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_data_q  <= in_data;
        s1_tag_q   <= in_tag;
        s1_count_q <= lz_d;
        s1_zero_q  <= zero_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_norm_q  <= '0;
      s2_tag_q   <= '0;
      s2_count_q <= '0;
      s2_zero_q  <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_norm_q  <= s1_data_q << s1_count_q;
        s2_tag_q   <= s1_tag_q;
        s2_count_q <= s1_count_q;
        s2_zero_q  <= s1_zero_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_norm  = s2_norm_q;
  assign out_tag   = s2_tag_q;
  assign out_count = s2_count_q;
  assign out_zero  = s2_zero_q;

`ifdef LZC_ZERO_CNT_EN
  logic [15:0] zero_events_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_events_q <= 16'h0000;
    end else if (s2_valid_q && out_ready && s2_zero_q && (zero_events_q != 16'hFFFF)) begin
      zero_events_q <= zero_events_q + 16'd1;
    end
  end

  assign zero_events = zero_events_q;
`else
  assign zero_events = 16'h0000;
`endif

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// tb/tb_lzc_norm_pipe.sv - directed self-checking bench for lzc_norm_pipe (W=24 and W=5 instances).
module tb_lzc_norm_pipe;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [23:0] in_data, out_norm;
  logic [3:0]  in_tag, out_tag;
  logic [4:0]  out_count;
  logic [15:0] zero_events;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero;
  logic [4:0]  b_in_data, b_out_norm;
  logic [1:0]  b_in_tag, b_out_tag;
  logic [2:0]  b_out_count;
  logic [15:0] b_zero_events;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  lzc_norm_pipe #(.W(24), .TAG_W(4)) u_w24 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_zero(out_zero), .out_norm(out_norm), .out_tag(out_tag),
    .zero_events(zero_events)
  );

  lzc_norm_pipe #(.W(5), .TAG_W(2)) u_w5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_count(b_out_count),
    .out_zero(b_out_zero), .out_norm(b_out_norm), .out_tag(b_out_tag),
    .zero_events(b_zero_events)
  );

  task automatic test_reset;
    @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, in_ready, out_count, out_zero, out_norm, out_tag, zero_events} !==
        {1'b0, 1'b1, 5'd0, 1'b0, 24'd0, 4'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_w24: got %h expected %h",
               {out_valid, in_ready, out_count, out_zero, out_norm, out_tag, zero_events},
               {1'b0, 1'b1, 5'd0, 1'b0, 24'd0, 4'd0, 16'd0});
    end
    vectors++;
    if ({b_out_valid, b_in_ready, b_out_count, b_out_zero, b_out_norm, b_out_tag} !==
        {1'b0, 1'b1, 3'd0, 1'b0, 5'd0, 2'd0}) begin
      errors++;
      $display("FAIL reset_w5: got %h expected %h",
               {b_out_valid, b_in_ready, b_out_count, b_out_zero, b_out_norm, b_out_tag},
               {1'b0, 1'b1, 3'd0, 1'b0, 5'd0, 2'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    @(negedge clk);
    in_valid = 1'b1; in_data = 24'h00F000; in_tag = 4'd3; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_data = 24'hABCDEF; in_tag = 4'hF;
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: got out_valid %b expected 0", out_valid);
    end
    @(negedge clk);
    vectors++;
    if ({out_valid, out_count, out_zero, out_norm, out_tag} !== {1'b1, 5'd8, 1'b0, 24'hF00000, 4'd3}) begin
      errors++;
      $display("FAIL single_result: got %h expected %h",
               {out_valid, out_count, out_zero, out_norm, out_tag}, {1'b1, 5'd8, 1'b0, 24'hF00000, 4'd3});
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_after: got out_valid %b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [23:0] din [3];
    logic [34:0] exp_v [4];
    din[0] = 24'h800000; din[1] = 24'h000001; din[2] = 24'h000000;
    exp_v[0] = {1'b1, 5'd0,  1'b0, 24'h800000, 4'd1};
    exp_v[1] = {1'b1, 5'd23, 1'b0, 24'h800000, 4'd2};
    exp_v[2] = {1'b1, 5'd0,  1'b1, 24'h000000, 4'd3};
    exp_v[3] = {1'b0, 5'd0,  1'b1, 24'h000000, 4'd3};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        vectors++;
        if ({out_valid, out_count, out_zero, out_norm, out_tag} !== exp_v[k-2]) begin
          errors++;
          $display("FAIL back_to_back[%0d]: got %h expected %h", k-2,
                   {out_valid, out_count, out_zero, out_norm, out_tag}, exp_v[k-2]);
        end
      end
      if (k < 3) begin
        in_valid = 1'b1; in_data = din[k]; in_tag = 4'(k + 1);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure;
    logic [23:0] din [5];
    logic [33:0] exp_v [5];
    logic [33:0] held;
    logic        held_v;
    int          sent, rcv;
    din[0] = 24'h400000; din[1] = 24'h000300; din[2] = 24'h0000FF;
    din[3] = 24'h123456; din[4] = 24'h000000;
    exp_v[0] = {5'd1,  1'b0, 24'h800000, 4'd5};
    exp_v[1] = {5'd14, 1'b0, 24'hC00000, 4'd6};
    exp_v[2] = {5'd16, 1'b0, 24'hFF0000, 4'd7};
    exp_v[3] = {5'd3,  1'b0, 24'h91A2B0, 4'd8};
    exp_v[4] = {5'd0,  1'b1, 24'h000000, 4'd9};
    sent = 0; rcv = 0; held = '0; held_v = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 7);
      if (sent < 5) begin
        in_valid = 1'b1; in_data = din[sent]; in_tag = 4'(sent + 5);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 3 && c <= 7) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready[c%0d]: got %b expected 0", c, in_ready);
        end
      end
      if (out_valid && held_v) begin
        vectors++;
        if ({out_count, out_zero, out_norm, out_tag} !== held) begin
          errors++;
          $display("FAIL bp_hold[c%0d]: got %h expected %h", c, {out_count, out_zero, out_norm, out_tag}, held);
        end
      end
      if (out_valid && !out_ready) begin
        held = {out_count, out_zero, out_norm, out_tag}; held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (rcv >= 5) begin
          errors++;
          $display("FAIL bp_extra: got result %0d expected at most 5", rcv + 1);
        end else if ({out_count, out_zero, out_norm, out_tag} !== exp_v[rcv]) begin
          errors++;
          $display("FAIL bp_order[%0d]: got %h expected %h", rcv, {out_count, out_zero, out_norm, out_tag}, exp_v[rcv]);
        end
        rcv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    vectors++;
    if (rcv !== 5) begin
      errors++;
      $display("FAIL bp_count: got %0d results expected 5", rcv);
    end
  endtask

  task automatic test_reset_flight;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 24'h010000; in_tag = 4'd1;
    @(negedge clk);
    in_data = 24'h000020; in_tag = 4'd2;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flight_setup: got out_valid %b expected 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL flight_async: got valid/ready %b expected 01", {out_valid, in_ready});
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flight_stale[%0d]: got out_valid %b expected 0", k, out_valid);
      end
    end
  endtask

  task automatic test_non_pow2;
    logic [4:0]  din [3];
    logic [11:0] exp_v [4];
    din[0] = 5'b00110; din[1] = 5'b00001; din[2] = 5'b10000;
    exp_v[0] = {1'b1, 3'd2, 1'b0, 5'b11000, 2'd1};
    exp_v[1] = {1'b1, 3'd4, 1'b0, 5'b10000, 2'd2};
    exp_v[2] = {1'b1, 3'd0, 1'b0, 5'b10000, 2'd3};
    exp_v[3] = {1'b0, 3'd0, 1'b0, 5'b10000, 2'd3};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        vectors++;
        if ({b_out_valid, b_out_count, b_out_zero, b_out_norm, b_out_tag} !== exp_v[k-2]) begin
          errors++;
          $display("FAIL non_pow2[%0d]: got %h expected %h", k-2,
                   {b_out_valid, b_out_count, b_out_zero, b_out_norm, b_out_tag}, exp_v[k-2]);
        end
      end
      if (k < 3) begin
        b_in_valid = 1'b1; b_in_data = din[k]; b_in_tag = 2'(k + 1);
      end else begin
        b_in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_zero_events;
    logic [23:0] din [5];
    logic [15:0] exp_cnt;
    din[0] = 24'h0; din[1] = 24'h0; din[2] = 24'h000005; din[3] = 24'h0; din[4] = 24'h000001;
`ifdef LZC_ZERO_CNT_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    @(negedge clk);
    rst_n = 1'b0; out_ready = 1'b1;
    #1 rst_n = 1'b1;
    vectors++;
    if (zero_events !== 16'd0) begin
      errors++;
      $display("FAIL zev_reset: got %h expected 0000", zero_events);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 5) begin
        in_valid = 1'b1; in_data = din[k]; in_tag = 4'(k);
      end else begin
        in_valid = 1'b0;
      end
    end
    vectors++;
    if (zero_events !== exp_cnt) begin
      errors++;
      $display("FAIL zev_count: got %h expected %h", zero_events, exp_cnt);
    end
`ifdef LZC_ZERO_CNT_EN
    in_valid = 1'b1; in_data = 24'h0;
    for (int k = 0; k < 65537; k++) @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (zero_events !== 16'hFFFF) begin
      errors++;
      $display("FAIL zev_saturate: got %h expected ffff", zero_events);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_tag = '0; b_out_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_flight();
    test_non_pow2();
    test_zero_events();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
